// File: rtl/fetch_unit.sv
// Instruction fetch stage. It keeps at most one memory request in flight and
// parks each returned word in a one-entry buffer ahead of the F/D register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        pc_en_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_d_o,
  output logic [31:0] pc_d_o,
  output logic        valid_d_o,
  output logic [6:0]  opF_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        kill;
  logic        fbuf_valid;
  logic [31:0] fbuf_instr;
  logic [31:0] fbuf_pc;
  logic        drain;
  logic        issue;

  // A new fetch may start only if its word is certain to find room in the buffer.
  assign drain = !flush_i && !stall_i;
  assign issue = (state == S_IDLE) && pc_en_i && !flush_i && (!fbuf_valid || drain);

  assign imem_req_o  = issue && rstn_i;
  assign imem_addr_o = pc;
  assign opF_o       = fbuf_valid ? fbuf_instr[6:0] : 7'b0010011;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      kill       <= 1'b0;
      fbuf_valid <= 1'b0;
      fbuf_instr <= NOP_INSTR;
      fbuf_pc    <= 32'h0;
      instr_d_o  <= NOP_INSTR;
      pc_d_o     <= 32'h0;
      valid_d_o  <= 1'b0;
    end else if (flush_i) begin
      pc         <= {branch_target_i[31:2], 2'b00};
      fbuf_valid <= 1'b0;
      instr_d_o  <= NOP_INSTR;
      valid_d_o  <= 1'b0;
      // A response still in flight belongs to the squashed path and must be dropped.
      if (state == S_WAIT) begin
        if (imem_rvalid_i) begin
          state <= S_IDLE;
          kill  <= 1'b0;
        end else begin
          kill  <= 1'b1;
        end
      end
    end else begin
      if (!stall_i) begin
        fbuf_valid <= 1'b0;
        if (fbuf_valid) begin
          instr_d_o <= fbuf_instr;
          pc_d_o    <= fbuf_pc;
          valid_d_o <= 1'b1;
        end else begin
          instr_d_o <= NOP_INSTR;
          valid_d_o <= 1'b0;
        end
      end
      if (issue) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
        state  <= S_WAIT;
      end
      if ((state == S_WAIT) && imem_rvalid_i) begin
        state <= S_IDLE;
        kill  <= 1'b0;
        if (!kill) begin
          fbuf_valid <= 1'b1;
          fbuf_instr <= imem_rdata_i;
          fbuf_pc    <= req_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run, all
// compared against a transaction-level model built from request/buffer queues.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        dropped;
  } req_t;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        pc_en_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_d_o;
  logic [31:0] pc_d_o;
  logic        valid_d_o;
  logic [6:0]  opF_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: in-flight requests, buffered words, and the F/D contents.
  req_t        oq[$];
  fetch_t      fbq[$];
  logic [31:0] m_pc;
  logic [31:0] m_fd_instr;
  logic [31:0] m_fd_pc;
  logic        m_fd_valid;

  logic        obs_req;
  logic [31:0] obs_addr;
  logic        last_issue;
  logic        mem_pending;
  int          mem_cnt;

  fetch_unit dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .pc_en_i         (pc_en_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_d_o       (instr_d_o),
    .pc_d_o          (pc_d_o),
    .valid_d_o       (valid_d_o),
    .opF_o           (opF_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    oq.delete();
    fbq.delete();
    m_pc       = 32'h0;
    m_fd_instr = NOP;
    m_fd_pc    = 32'h0;
    m_fd_valid = 1'b0;
    mem_pending = 1'b0;
    mem_cnt     = 0;
  endtask

  task automatic modelUpdate(input logic st, input logic fl, input logic [31:0] tgt,
                             input logic rv, input logic [31:0] rd, input logic iss);
    fetch_t e;
    req_t   r;
    if (fl) begin
      m_fd_instr = NOP;
      m_fd_valid = 1'b0;
      fbq.delete();
      m_pc = tgt & 32'hFFFF_FFFC;
      if (oq.size() > 0) begin
        if (rv) void'(oq.pop_front());
        else foreach (oq[i]) oq[i].dropped = 1'b1;
      end
    end else begin
      if (!st) begin
        if (fbq.size() > 0) begin
          e = fbq.pop_front();
          m_fd_instr = e.instr;
          m_fd_pc    = e.pc;
          m_fd_valid = 1'b1;
        end else begin
          m_fd_instr = NOP;
          m_fd_valid = 1'b0;
        end
      end
      if (rv && oq.size() > 0) begin
        r = oq.pop_front();
        if (!r.dropped) begin
          e.instr = rd;
          e.pc    = r.pc;
          fbq.push_back(e);
        end
      end
      if (iss) begin
        r.pc = m_pc;
        r.dropped = 1'b0;
        oq.push_back(r);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check the request just after,
  // advance the model on the rising edge, check F/D at the next falling edge.
  task automatic applyStimulus(input logic pe, input logic st, input logic fl,
                               input logic [31:0] tgt, input logic rv, input logic [31:0] rd);
    logic exp_issue;
    pc_en_i = pe;
    stall_i = st;
    flush_i = fl;
    branch_target_i = tgt;
    imem_rvalid_i = rv;
    imem_rdata_i = rd;
    #1;
    exp_issue = (oq.size() == 0) && pe && !fl && ((fbq.size() == 0) || !st);
    obs_req  = imem_req_o;
    obs_addr = imem_addr_o;
    checkOutput("imem_req", {31'b0, imem_req_o}, {31'b0, exp_issue});
    if (exp_issue) checkOutput("imem_addr", imem_addr_o, m_pc);
    last_issue = exp_issue;
    @(posedge clk_i);
    modelUpdate(st, fl, tgt, rv, rd, exp_issue);
    @(negedge clk_i);
    checkOutput("instr_d", instr_d_o, m_fd_instr);
    checkOutput("pc_d", pc_d_o, m_fd_pc);
    checkOutput("valid_d", {31'b0, valid_d_o}, {31'b0, m_fd_valid});
    checkOutput("opF", {25'b0, opF_o}, (fbq.size() > 0) ? {25'b0, fbq[0].instr[6:0]} : 32'h13);
  endtask

  task automatic doReset();
    rstn_i = 1'b0;
    pc_en_i = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    branch_target_i = 32'h0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0;
    #1;
    checkOutput("rst_req", {31'b0, imem_req_o}, 32'h0);
    @(negedge clk_i);
    checkOutput("rst_instr_d", instr_d_o, NOP);
    checkOutput("rst_pc_d", pc_d_o, 32'h0);
    checkOutput("rst_valid_d", {31'b0, valid_d_o}, 32'h0);
    checkOutput("rst_opF", {25'b0, opF_o}, 32'h13);
    checkOutput("rst_req_hold", {31'b0, imem_req_o}, 32'h0);
    modelReset();
    rstn_i = 1'b1;
  endtask

  initial begin
    logic pe, st, fl, rv;
    logic [31:0] tgt, rd;
    rstn_i = 1'b0;
    pc_en_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    branch_target_i = 32'h0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0;
    modelReset();
    @(negedge clk_i);
    doReset();

    // First fetch after reset and its two-cycle path into F/D.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t34_req", {31'b0, obs_req}, 32'h1);
    checkOutput("t34_addr", obs_addr, 32'h0);
    applyStimulus(1, 0, 0, 0, 1, 32'h0050_0093);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t34_next_addr", obs_addr, 32'h4);
    checkOutput("t34_instr", instr_d_o, 32'h0050_0093);
    checkOutput("t34_pc", pc_d_o, 32'h0);
    checkOutput("t34_valid", {31'b0, valid_d_o}, 32'h1);
    applyStimulus(0, 0, 0, 0, 1, 32'h0020_81B3);

    // Stall with a full buffer and fetch disabled.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("t35_req", {31'b0, obs_req}, 32'h0);
      checkOutput("t35_opF", {25'b0, opF_o}, 32'h33);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t35_rel_pc", pc_d_o, 32'h4);
    checkOutput("t35_rel_instr", instr_d_o, 32'h0020_81B3);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t35_pc_held", obs_addr, 32'h8);

    // Flush while a request is outstanding; its late response is dropped.
    applyStimulus(0, 0, 1, 32'h100, 0, 0);
    checkOutput("t36_valid", {31'b0, valid_d_o}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("t36_no_req", {31'b0, obs_req}, 32'h0);
    end
    applyStimulus(1, 0, 0, 0, 1, 32'hBAD0_0013);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t36_addr", obs_addr, 32'h100);
    applyStimulus(1, 0, 0, 0, 1, 32'h0010_0113);

    // Flush coinciding with the response; misaligned target is aligned.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 32'h203, 1, 32'hBAD1_0013);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t37_addr", obs_addr, 32'h200);
    applyStimulus(0, 0, 0, 0, 1, 32'h0030_0193);

    // PC wraps from the top of the address space.
    applyStimulus(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t38_top", obs_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 1, 32'h0040_0213);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t38_wrap", obs_addr, 32'h0);

    // Reset while waiting; a stale response right after release is ignored.
    doReset();
    applyStimulus(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("t39_addr", obs_addr, 32'h0);
    applyStimulus(1, 0, 0, 0, 1, 32'h0070_0193);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t39_instr", instr_d_o, 32'h0070_0193);

    // Randomized traffic with a memory of 1..3 cycle latency.
    doReset();
    for (int c = 0; c < 600; c++) begin
      pe  = ($urandom % 4) != 0;
      st  = ($urandom % 4) == 0;
      fl  = ($urandom % 10) == 0;
      tgt = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      rd  = $urandom;
      rv  = 1'b0;
      if (mem_pending) begin
        mem_cnt--;
        rv = (mem_cnt == 0);
      end else begin
        rv = ($urandom % 8) == 0;
      end
      applyStimulus(pe, st, fl, tgt, rv, rd);
      if (rv && mem_pending) mem_pending = 1'b0;
      if (last_issue) begin
        mem_pending = 1'b1;
        mem_cnt = $urandom_range(1, 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
